// File: rtl/ch4_lfsr.sv
// APU channel-4 noise generator: programmable divider clocking a 15-bit LFSR with optional 7-bit tap.
// Latency: outputs registered; first lfsr_tick exactly P cycles after the restart edge, then every P cycles.
// Backpressure: none; ch4_on=0 freezes the divider and LFSR. Optional macro CH4_SHIFT_STOP_EN halts on shift 14/15.
module ch4_lfsr #(
    parameter int LFSR_W = 15,
    parameter int CNT_W  = 19
) (
    input  logic              ajer_2mhz,
    input  logic              apu_reset,
    input  logic              ch4_restart,
    input  logic              ch4_on,
    input  logic [3:0]        ff22_shift,
    input  logic              ff22_width7,
    input  logic [2:0]        ff22_div,
    output logic              ch4_bit,
    output logic              lfsr_tick,
    output logic [LFSR_W-1:0] lfsr_q
);

    logic [CNT_W-1:0]  cnt;
    logic [LFSR_W-1:0] lfsr;
    logic              tick_q;
    logic [5:0]        base;
    logic [3:0]        shift_eff;
    logic [CNT_W-1:0]  period;
    logic              fb;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic              shift_stop;

`ifdef CH4_SHIFT_STOP_EN
    assign shift_stop = (ff22_shift >= 4'd14);
`else
    assign shift_stop = 1'b0;
`endif

    always_comb begin
        base = 6'd4;
        case (ff22_div)
            3'd0:    base = 6'd4;
            3'd1:    base = 6'd8;
            3'd2:    base = 6'd16;
            3'd3:    base = 6'd24;
            3'd4:    base = 6'd32;
            3'd5:    base = 6'd40;
            3'd6:    base = 6'd48;
            default: base = 6'd56;
        endcase
        // Shift codes 14/15 clamp to 13 so the period always fits the counter.
        shift_eff = (ff22_shift > 4'd13) ? 4'd13 : ff22_shift;
        period    = CNT_W'(base) << shift_eff;
    end

    always_comb begin
        fb       = ~(lfsr[0] ^ lfsr[1]);
        lfsr_nxt = {fb, lfsr[LFSR_W-1:1]};
        if (ff22_width7) begin
            lfsr_nxt[6] = fb;
        end
    end

    always_ff @(posedge ajer_2mhz) begin
        if (apu_reset) begin
            lfsr   <= '0;
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (ch4_restart) begin
            lfsr   <= '0;
            cnt    <= period;
            tick_q <= 1'b0;
        end else if (ch4_on && (cnt != '0) && !shift_stop) begin
            if (cnt == CNT_W'(1)) begin
                // Reload uses the FF22 fields live at this edge, so mid-count writes land here.
                cnt    <= period;
                lfsr   <= lfsr_nxt;
                tick_q <= 1'b1;
            end else begin
                cnt    <= cnt - CNT_W'(1);
                tick_q <= 1'b0;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign ch4_bit   = lfsr[0];
    assign lfsr_tick = tick_q;
    assign lfsr_q    = lfsr;

endmodule

// File: tb/tb_ch4_lfsr.sv
// Directed bench for ch4_lfsr: divider periods, LFSR sequences, restart/reset/enable corner cases.
module tb_ch4_lfsr;

    logic        ajer_2mhz = 1'b0;
    logic        apu_reset;
    logic        ch4_restart;
    logic        ch4_on;
    logic [3:0]  ff22_shift;
    logic        ff22_width7;
    logic [2:0]  ff22_div;
    logic        ch4_bit;
    logic        lfsr_tick;
    logic [14:0] lfsr_q;

    int checks = 0;
    int errors = 0;
    int n;
    int t;

    logic [14:0] seq15 [15] = '{15'h4000, 15'h6000, 15'h7000, 15'h7800, 15'h7C00,
                                15'h7E00, 15'h7F00, 15'h7F80, 15'h7FC0, 15'h7FE0,
                                15'h7FF0, 15'h7FF8, 15'h7FFC, 15'h7FFE, 15'h3FFF};

    ch4_lfsr dut (
        .ajer_2mhz   (ajer_2mhz),
        .apu_reset   (apu_reset),
        .ch4_restart (ch4_restart),
        .ch4_on      (ch4_on),
        .ff22_shift  (ff22_shift),
        .ff22_width7 (ff22_width7),
        .ff22_div    (ff22_div),
        .ch4_bit     (ch4_bit),
        .lfsr_tick   (lfsr_tick),
        .lfsr_q      (lfsr_q)
    );

    always #5 ajer_2mhz = ~ajer_2mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until a tick is seen (bounded); called on a negedge.
    task automatic wait_tick(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge ajer_2mhz);
            cyc++;
        end while (!lfsr_tick && cyc < budget);
    endtask

    task automatic count_ticks(input int cycles, output int cnt_t);
        cnt_t = 0;
        repeat (cycles) begin
            @(negedge ajer_2mhz);
            if (lfsr_tick) cnt_t++;
        end
    endtask

    task automatic do_restart(input logic [2:0] r, input logic [3:0] s, input logic w7);
        ff22_div    = r;
        ff22_shift  = s;
        ff22_width7 = w7;
        ch4_restart = 1'b1;
        @(negedge ajer_2mhz);
        ch4_restart = 1'b0;
    endtask

    initial begin
        apu_reset   = 1'b1;
        ch4_restart = 1'b0;
        ch4_on      = 1'b1;
        ff22_shift  = 4'd0;
        ff22_width7 = 1'b0;
        ff22_div    = 3'd0;
        repeat (3) @(negedge ajer_2mhz);
        chk("rst_lfsr", lfsr_q, 0);
        chk("rst_tick", lfsr_tick, 0);
        chk("rst_bit", ch4_bit, 0);
        apu_reset = 1'b0;

        count_ticks(20, t);
        chk("idle_no_tick", t, 0);

        do_restart(3'd0, 4'd0, 1'b0);
        chk("restart_lfsr", lfsr_q, 0);
        chk("restart_tick", lfsr_tick, 0);
        for (int k = 0; k < 15; k++) begin
            wait_tick(20, n);
            chk("w15_period", n, 4);
            chk("w15_lfsr", lfsr_q, seq15[k]);
            chk("w15_bit", ch4_bit, (k == 14) ? 1 : 0);
        end

        do_restart(3'd0, 4'd0, 1'b1);
        wait_tick(20, n);
        chk("w7_p1", n, 4);
        chk("w7_lfsr1", lfsr_q, 15'h4040);
        wait_tick(20, n);
        chk("w7_lfsr2", lfsr_q, 15'h6060);

        // Width switch mid-run keeps state; tap applies from next shift.
        do_restart(3'd0, 4'd0, 1'b0);
        wait_tick(20, n);
        ff22_width7 = 1'b1;
        wait_tick(20, n);
        chk("wswitch_lfsr", lfsr_q, 15'h6040);

        do_restart(3'd7, 4'd2, 1'b0);
        wait_tick(300, n);
        chk("p224_first", n, 224);
        chk("p224_lfsr", lfsr_q, 15'h4000);
        wait_tick(300, n);
        chk("p224_second", n, 224);

        do_restart(3'd1, 4'd0, 1'b0);
        repeat (3) @(negedge ajer_2mhz);
        ff22_div = 3'd3;
        wait_tick(50, n);
        chk("ff22_mid_rest", n, 5);
        wait_tick(50, n);
        chk("ff22_new_period", n, 24);

        // Restart lands on the would-be tick edge.
        do_restart(3'd0, 4'd0, 1'b0);
        wait_tick(20, n);
        wait_tick(20, n);
        chk("pre_coin_lfsr", lfsr_q, 15'h6000);
        repeat (3) @(negedge ajer_2mhz);
        ch4_restart = 1'b1;
        @(negedge ajer_2mhz);
        ch4_restart = 1'b0;
        chk("coin_tick", lfsr_tick, 0);
        chk("coin_lfsr", lfsr_q, 0);
        wait_tick(20, n);
        chk("coin_after", n, 4);

        // Reset on the would-be tick edge.
        repeat (3) @(negedge ajer_2mhz);
        apu_reset = 1'b1;
        @(negedge ajer_2mhz);
        apu_reset = 1'b0;
        chk("midrst_tick", lfsr_tick, 0);
        chk("midrst_lfsr", lfsr_q, 0);
        count_ticks(30, t);
        chk("midrst_idle", t, 0);

        do_restart(3'd0, 4'd2, 1'b0);
        wait_tick(40, n);
        chk("on_p16", n, 16);
        repeat (5) @(negedge ajer_2mhz);
        ch4_on = 1'b0;
        count_ticks(10, t);
        chk("on_hold_ticks", t, 0);
        chk("on_hold_lfsr", lfsr_q, 15'h4000);
        ch4_on = 1'b1;
        wait_tick(40, n);
        chk("on_hold_rest", n, 11);

        ch4_on = 1'b0;
        do_restart(3'd0, 4'd0, 1'b0);
        chk("off_restart_lfsr", lfsr_q, 0);
        ch4_on = 1'b1;
        wait_tick(20, n);
        chk("off_restart_period", n, 4);

`ifdef CH4_SHIFT_STOP_EN
        do_restart(3'd0, 4'd14, 1'b0);
        chk("stop_lfsr", lfsr_q, 0);
        count_ticks(40000, t);
        chk("stop_no_tick", t, 0);
        chk("stop_lfsr_held", lfsr_q, 0);
`else
        do_restart(3'd0, 4'd14, 1'b0);
        wait_tick(40000, n);
        chk("s14_clamp", n, 32768);
        chk("s14_lfsr", lfsr_q, 15'h4000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
